// File: rtl/alu_secuenciador_pkg.sv
// Shared definitions for the ALU command sequencer: default sizes,
// ALU select codes and the sequencer FSM state encodings.
package alu_secuenciador_pkg;

    // Default data width (must match the ALU) and register file depth
    localparam int DEF_N    = 3;
    localparam int DEF_NREG = 4;

    // ALU select codes; 10..15 make the ALU output zero
    localparam logic [3:0] SEL_ADD = 4'd0;
    localparam logic [3:0] SEL_SUB = 4'd1;
    localparam logic [3:0] SEL_INC = 4'd2;
    localparam logic [3:0] SEL_DEC = 4'd3;
    localparam logic [3:0] SEL_AND = 4'd4;
    localparam logic [3:0] SEL_OR  = 4'd5;
    localparam logic [3:0] SEL_NOT = 4'd6;
    localparam logic [3:0] SEL_XOR = 4'd7;
    localparam logic [3:0] SEL_SHL = 4'd8;
    localparam logic [3:0] SEL_SHR = 4'd9;

    // Sequencer states; encoding 2'd3 is unreachable and recovers to idle
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/alu_banco_reg.sv
// Register file for the sequencer: NREG x N, one synchronous write port,
// two asynchronous operand read ports and an asynchronous debug read port.
module alu_banco_reg
    import alu_secuenciador_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int NREG = DEF_NREG,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [AW-1:0] ra_addr,
    input  logic [AW-1:0] rb_addr,
    input  logic [AW-1:0] dbg_addr,
    output logic [N-1:0]  ra_data,
    output logic [N-1:0]  rb_data,
    output logic [N-1:0]  dbg_data
);

    logic [N-1:0] rf [NREG];

    // Clear every register on reset, otherwise write one entry when enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (we) begin
            rf[waddr] <= wdata;
        end
    end

    assign ra_data  = rf[ra_addr];
    assign rb_data  = rf[rb_addr];
    assign dbg_data = rf[dbg_addr];

endmodule

// File: rtl/alu_secuenciador.sv
// Command sequencer for an external combinational ALU. Accepts one command
// at a time (valid/ready), presents registered operands to the ALU, then
// writes the result (or an immediate) back and pulses done.
module alu_secuenciador
    import alu_secuenciador_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int NREG = DEF_NREG,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_ld,
    input  logic [3:0]    cmd_sel,
    input  logic          cmd_flagin,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_ra,
    input  logic [AW-1:0] cmd_rb,
    input  logic [N-1:0]  cmd_imm,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    output logic          alu_flagin,
    output logic [3:0]    alu_select,
    input  logic [N-1:0]  alu_res,
    input  logic          alu_neg,
    input  logic          alu_zero,
    input  logic          alu_cout,
    input  logic          alu_ovf,
    output logic [3:0]    flags,
    output logic          done,
    input  logic [AW-1:0] dbg_addr,
    output logic [N-1:0]  dbg_data
);

    state_t        state;
    state_t        state_next;
    logic          accept;
    logic          ld_q;
    logic [AW-1:0] rd_q;
    logic [N-1:0]  imm_q;
    logic          rf_we;
    logic [N-1:0]  rf_wdata;
    logic [N-1:0]  ra_data;
    logic [N-1:0]  rb_data;

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign done      = (state == ST_DONE);
    assign rf_we     = (state == ST_EXEC);
    assign rf_wdata  = ld_q ? imm_q : alu_res;

    alu_banco_reg #(
        .N    (N),
        .NREG (NREG),
        .AW   (AW)
    ) u_banco (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (rd_q),
        .wdata    (rf_wdata),
        .ra_addr  (cmd_ra),
        .rb_addr  (cmd_rb),
        .dbg_addr (dbg_addr),
        .ra_data  (ra_data),
        .rb_data  (rb_data),
        .dbg_data (dbg_data)
    );

    // Next-state logic: idle -> exec on accept, exec -> done -> idle
    always_comb begin
        state_next = ST_IDLE;
        case (state)
            ST_IDLE: state_next = accept ? ST_EXEC : ST_IDLE;
            ST_EXEC: state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Snapshot operands and command fields at accept; they hold until the next accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_flagin <= 1'b0;
            alu_select <= 4'd0;
            ld_q       <= 1'b0;
            rd_q       <= '0;
            imm_q      <= '0;
        end else if (accept) begin
            alu_a      <= ra_data;
            alu_b      <= rb_data;
            alu_flagin <= cmd_flagin;
            alu_select <= cmd_sel;
            ld_q       <= cmd_ld;
            rd_q       <= cmd_rd;
            imm_q      <= cmd_imm;
        end
    end

    // Capture ALU flags at the end of an ALU op; loads leave them untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= 4'd0;
        end else if (state == ST_EXEC && !ld_q) begin
            flags <= {alu_neg, alu_zero, alu_cout, alu_ovf};
        end
    end

endmodule
